prescaler_bank: RTL and testbench
=================================

# prescaler_bank

Multi-channel, runtime-programmable clock prescaler, the parametrised successor to the fixed-`DIV_FACTOR` prescaler. Each of `NUM_CH` channels divides `clk` by its own divisor. Each channel:
- has its own enable;
- produces a divided square wave and a one-cycle period-end tick;
- accepts new divisors through a shadow register that takes effect only at a period boundary, so outputs never glitch;
- can be phase-aligned with the other channels by a common `sync` strobe.

It sits between the system clock and the slow timing consumers (LED/mood timers, sampling strobes).

## Interface

Parameters:
- `NUM_CH`, 4: number of channels (≥1).
- `CNT_W`, 8: divisor/counter width; maximum divisor is 2^CNT_W−1.
- `DEFAULT_DIV`, 4: divisor loaded into every channel at reset (1..2^CNT_W−1).

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `en`  in  NUM_CH: per-channel run enable (level).
- `sync`  in  1: one-cycle strobe that restarts all enabled channels at phase 0.
- `cfg_we`  in  1: write strobe for the divisor shadow register.
- `cfg_ch`  in  max(1,$clog2(NUM_CH)): channel index for the write.
- `cfg_div`  in  CNT_W: new divisor.
- `clk_out`  out  NUM_CH: divided clock per channel (registered).
- `tick`  out  NUM_CH: one-cycle strobe in the last cycle of each period (registered).
- `pending`  out  NUM_CH: shadow divisor written but not yet applied.

## Operation

Per-channel state:
- `run`: running flag.
- `p`: phase counter, CNT_W bits.
- `D`: active divisor.
- `S`: shadow divisor.
- `pnd`: pending flag.

Derived value: H = (D+1)>>1, the high-phase length, so the high phase is the longer half for odd D.

Reset (async, `rst_n`=0):
- `run`=0, `p`=0, `D`=`S`=`DEFAULT_DIV`, `pnd`=0.
- `clk_out`=0, `tick`=0, `pending`=0.

Config writes:
- When `cfg_we`=1 at an edge: `S[cfg_ch]`←`cfg_div`, `pnd`←1.
- `cfg_div`=0 is stored as 1.
- `cfg_ch`≥`NUM_CH` is ignored.
- A later write before the boundary overwrites `S`; the last value wins.

Period start (PS) is entered when any of the following occurs at an edge:
- `en`=1 while `run`=0 (start);
- `run`=1 and `p`=D−1 (wrap);
- `sync`=1 and `en`=1 (resync).

At PS:
- `p`←0.
- If `pnd`: `D`←`S`, `pnd`←0. The applied value is the `S` before this edge.
- `run`←1.

Otherwise, while running: `p`←`p`+1.

Disable: `en`=0 at an edge makes `run`←0 and `p`←0, and `clk_out` and `tick` go to 0 at that edge. Shadow state is kept.

Outputs are registered from the next state, so in phase p:
- `clk_out`=1 iff `run` and p<H.
- `tick`=1 iff `run` and p=D−1.
- Divisor D=1: `clk_out` and `tick` are constantly 1 while running.

Priority, highest first: reset > `en`=0 > `sync` > wrap > increment.

Simultaneous events:
- A `cfg_we` on the same edge as a PS is not applied at that PS. It becomes pending for the next PS.
- If the same edge also applies an older pending value, `pnd` is still set to 1 because of the new write.

## Timing

- Start: `en` sampled high at edge E0 → `clk_out`=1 from E0 for H cycles, then 0 for D−H cycles.
- Period is exactly D cycles.
- `tick` is high for one cycle after edge E0+D−1.
- Stop: latency is 1 edge, and the current period may be truncated.
- Divisor change: applied at the first PS after the write edge. Output pulses stay whole; there are no runt pulses except through `sync` or disable.
- `sync`: all enabled channels show phase 0 after the same edge, so their rising edges of `clk_out` align. Disabled channels ignore it.
- `pending` mirrors `pnd`, registered: it rises the edge after `cfg_we` and falls at the applying PS edge.

## Test plan

- Reset then `en`=4'b1111, defaults (DEFAULT_DIV=4) → each `clk_out` shows 2 high / 2 low, with `tick` in every 4th cycle aligned to the last low cycle.
- Write ch1 `cfg_div`=5 mid-period → `pending[1]`=1, the current 4-cycle period completes, then 3 high / 2 low; `pending[1]` clears at that PS.
- `cfg_div`=0 on ch2 and `cfg_div`=1 on ch3 → both give `clk_out`=1 and `tick`=1 every cycle after the applying PS.
- Ch0 div 3, ch1 div 7, free-running, then `sync` pulse → both `clk_out` rise after the same edge. `sync` while `en[2]`=0 leaves ch2 outputs at 0.
- Drop `en[0]` during a high phase → `clk_out[0]`=0 and `tick[0]`=0 after one edge. Re-enable → a full first period of the current D follows.
- Assert `rst_n`=0 asynchronously mid-period with a pending write → all outputs go to 0 immediately, and after release the divisor is DEFAULT_DIV and `pending`=0.

Source files
------------

// File: rtl/prescaler_bank.sv
// prescaler_bank: multi-channel programmable clock prescaler.
// Each channel divides clk by its active divisor D and produces:
//   - a registered square wave: high for H=(D+1)>>1 cycles, then low;
//   - a one-cycle tick in the last cycle of each period.
// New divisors are written into a shadow register. They are applied only at
// a period start, so the output pulses stay whole.
// Ports:
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   en[NUM_CH]        : per-channel run enable (level)
//   sync              : restarts all enabled channels at phase 0
//   cfg_we/ch/div     : shadow divisor write (div 0 is stored as 1,
//                       out-of-range channel is ignored)
//   clk_out, tick     : registered divided clock and period-end strobe
//   pending           : shadow written but not yet applied
module prescaler_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_CH-1:0]                            en,
  input  logic                                         sync,
  input  logic                                         cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                             cfg_div,
  output logic [NUM_CH-1:0]                            clk_out,
  output logic [NUM_CH-1:0]                            tick,
  output logic [NUM_CH-1:0]                            pending
);

  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] pnd_q, pnd_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [CNT_W-1:0]  p_q [NUM_CH];
  logic [CNT_W-1:0]  p_d [NUM_CH];
  logic [CNT_W-1:0]  d_q [NUM_CH];
  logic [CNT_W-1:0]  d_d [NUM_CH];
  logic [CNT_W-1:0]  s_q [NUM_CH];
  logic [CNT_W-1:0]  s_d [NUM_CH];
  logic [CNT_W:0]    half;

  always_comb begin
    run_d     = run_q;
    pnd_d     = pnd_q;
    clk_out_d = '0;
    tick_d    = '0;
    half      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      p_d[i] = p_q[i];
      d_d[i] = d_q[i];
      s_d[i] = s_q[i];

      if (!en[i]) begin
        run_d[i] = 1'b0;
        p_d[i]   = '0;
      end else if (!run_q[i] || sync || (p_q[i] == d_q[i] - CNT_W'(1))) begin
        // Period start: the shadow applied here is the value before this
        // edge; a write on this same edge is handled below and stays pending.
        p_d[i]   = '0;
        run_d[i] = 1'b1;
        if (pnd_q[i]) begin
          d_d[i]   = s_q[i];
          pnd_d[i] = 1'b0;
        end
      end else begin
        p_d[i] = p_q[i] + CNT_W'(1);
      end

      if (cfg_we && (32'(cfg_ch) == i)) begin
        s_d[i]   = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
        pnd_d[i] = 1'b1;
      end

      // Outputs are decoded from the next state so they register in phase.
      half         = ({1'b0, d_d[i]} + (CNT_W + 1)'(1)) >> 1;
      clk_out_d[i] = run_d[i] && ({1'b0, p_d[i]} < half);
      tick_d[i]    = run_d[i] && (p_d[i] == d_d[i] - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= '0;
      pnd_q     <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        p_q[i] <= '0;
        d_q[i] <= CNT_W'(DEFAULT_DIV);
        s_q[i] <= CNT_W'(DEFAULT_DIV);
      end
    end else begin
      run_q     <= run_d;
      pnd_q     <= pnd_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        p_q[i] <= p_d[i];
        d_q[i] <= d_d[i];
        s_q[i] <= s_d[i];
      end
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pnd_q;

endmodule

// File: tb/tb_prescaler_bank.sv
// Testbench for prescaler_bank: directed scenarios plus a randomized phase,
// checked against a period-start-time model of each channel.
module tb_prescaler_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DEF    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out, tick, pending;

  int checks = 0;
  int errors = 0;

  // Model: each channel remembers the edge number its current period began
  // at, its divisor, shadow value and pending flag.
  int cyc = 0;
  int m_run [NUM_CH];
  int m_t0  [NUM_CH];
  int m_div [NUM_CH];
  int m_sh  [NUM_CH];
  int m_pnd [NUM_CH];

  prescaler_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_t0[c] = 0; m_div[c] = DEF; m_sh[c] = DEF; m_pnd[c] = 0;
    end
  endtask

  task automatic model_edge();
    int prev;
    for (int c = 0; c < NUM_CH; c++) begin
      prev = (cyc - 1) - m_t0[c];
      if (!en[c]) begin
        m_run[c] = 0;
      end else if (!m_run[c] || sync || prev == m_div[c] - 1) begin
        m_t0[c]  = cyc;
        m_run[c] = 1;
        if (m_pnd[c] != 0) begin
          m_div[c] = m_sh[c];
          m_pnd[c] = 0;
        end
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        m_sh[c]  = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_pnd[c] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_model();
    logic [NUM_CH-1:0] ec, et, ep;
    int age;
    for (int c = 0; c < NUM_CH; c++) begin
      age   = cyc - m_t0[c];
      ec[c] = (m_run[c] != 0) && (age < (m_div[c] + 1) / 2);
      et[c] = (m_run[c] != 0) && (age == m_div[c] - 1);
      ep[c] = (m_pnd[c] != 0);
    end
    chk("clk_out", 32'(clk_out), 32'(ec));
    chk("tick",    32'(tick),    32'(et));
    chk("pending", 32'(pending), 32'(ep));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_model();
  endtask

  logic [3:0] exp_c [5];
  logic [3:0] exp_t [5];
  int guard;

  initial begin
    rst_n = 1'b0; en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick",    32'(tick), 0);
    chk("rst_pending", 32'(pending), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Default divisor 4 on all channels: 2 high / 2 low, tick on last low.
    en = 4'hf;
    exp_c[0] = 4'hf; exp_c[1] = 4'hf; exp_c[2] = 4'h0; exp_c[3] = 4'h0; exp_c[4] = 4'hf;
    exp_t[0] = 4'h0; exp_t[1] = 4'h0; exp_t[2] = 4'h0; exp_t[3] = 4'hf; exp_t[4] = 4'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("dflt_clk", 32'(clk_out), 32'(exp_c[k]));
      chk("dflt_tick", 32'(tick), 32'(exp_t[k]));
    end

    // Mid-period write of divisor 5 to ch1.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    step();
    cfg_we = 1'b0;
    chk("pend1_set", 32'(pending[1]), 1);
    repeat (14) step();
    chk("pend1_clr", 32'(pending[1]), 0);

    // Divisor 0 on ch2 and 1 on ch3: constant high while running.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
    step();
    cfg_ch = 2'd3; cfg_div = 8'd1;
    step();
    cfg_we = 1'b0;
    repeat (8) step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("div1_clk", 32'(clk_out[3:2]), 32'h3);
      chk("div1_tick", 32'(tick[3:2]), 32'h3);
    end

    // ch0 div 3, ch1 div 7, then sync with ch2 disabled.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
    step();
    cfg_ch = 2'd1; cfg_div = 8'd7;
    step();
    cfg_we = 1'b0;
    repeat (20) step();
    en[2] = 1'b0;
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_align", 32'(clk_out[1:0]), 32'h3);
    chk("sync_ch2_clk", 32'(clk_out[2]), 0);
    chk("sync_ch2_tick", 32'(tick[2]), 0);
    repeat (3) step();
    en[2] = 1'b1;
    step();

    // Drop en[0] during a high phase, then re-enable.
    guard = 0;
    while (clk_out[0] !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    chk("find_high", 32'(clk_out[0]), 1);
    en[0] = 1'b0;
    step();
    chk("dis_clk", 32'(clk_out[0]), 0);
    chk("dis_tick", 32'(tick[0]), 0);
    step();
    en[0] = 1'b1;
    step();
    chk("reen_clk", 32'(clk_out[0]), 1);
    repeat (6) step();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      en      = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hf;
      sync    = ($urandom_range(0, 19) == 0);
      cfg_we  = ($urandom_range(0, 5) == 0);
      cfg_ch  = 2'($urandom);
      cfg_div = 8'($urandom_range(0, 9));
      step();
    end
    en = 4'hf; sync = 1'b0;

    // Async reset mid-period with a pending write.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
    step();
    cfg_we = 1'b0;
    chk("pre_rst_pend", 32'(pending[0]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_clk", 32'(clk_out), 0);
    chk("arst_tick", 32'(tick), 0);
    chk("arst_pend", 32'(pending), 0);
    model_reset();
    en = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    en = 4'hf;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_clk", 32'(clk_out), 32'(exp_c[k]));
      chk("post_rst_tick", 32'(tick), 32'(exp_t[k]));
    end
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
